ysyx_22041071_div_ctrl: RTL and testbench

//  Requester for the iterative divider (div_valid/div_ready/out_valid handshake). Sits in EXU between
//  the issue stage and the divider: decodes DIV/DIVU/REM/REMU(+W) and stalls EX while busy.

---
 rtl/ysyx_22041071_div_ctrl.sv | 136 +++++++++++++
 tb/tb_ysyx_22041071_div_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041071_div_ctrl.sv
// ysyx_22041071_div_ctrl: DIV/DIVU/REM/REMU(+W) requester in front of an iterative divider.
// Optional perf counters are enabled by defining YSYX_22041071_DIV_PERF_EN.
module ysyx_22041071_div_ctrl #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic [1:0]       ex_op,
    input  logic             ex_word,
    input  logic [XLEN-1:0]  ex_src1,
    input  logic [XLEN-1:0]  ex_src2,
    input  logic [TAG_W-1:0] ex_rd,
    input  logic             flush,
    output logic             ex_stall,
    output logic             res_valid,
    output logic [XLEN-1:0]  res_data,
    output logic [TAG_W-1:0] res_rd,
    output logic             div_valid,
    output logic             div_signed,
    output logic             divw,
    output logic [XLEN-1:0]  dividend,
    output logic [XLEN-1:0]  divisor,
    output logic             div_flush,
    input  logic             div_ready,
    input  logic             out_valid,
    input  logic [XLEN-1:0]  quot,
    input  logic [XLEN-1:0]  rema
`ifdef YSYX_22041071_DIV_PERF_EN
    ,
    output logic [63:0]      perf_div_ops,
    output logic [63:0]      perf_busy_cyc
`endif
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic              word_q, word_d;
    logic [XLEN-1:0]   src1_q, src1_d, src2_q, src2_d, res_q, res_d;
    logic [TAG_W-1:0]  rd_q, rd_d;
    logic              busy, dvz, ovf, special;
    logic [XLEN-1:0]   spec_raw;

    function automatic logic [XLEN-1:0] fmt(input logic w, input logic [XLEN-1:0] r);
        return w ? {{(XLEN-32){r[31]}}, r[31:0]} : r;
    endfunction

    // W ops judge only the low word; the overflow quotient is the dividend itself (MIN).
    assign dvz      = ex_word ? (ex_src2[31:0] == '0) : (ex_src2 == '0);
    assign ovf      = ~ex_op[0] & (ex_word ? (ex_src1[31:0] == 32'h8000_0000 && ex_src2[31:0] == '1)
                                           : (ex_src1 == {1'b1, {(XLEN-1){1'b0}}} && ex_src2 == '1));
    assign special  = dvz | ovf;
    assign spec_raw = ex_op[1] ? (dvz ? ex_src1 : '0) : (dvz ? '1 : ex_src1);

    assign busy       = state_q == BUSY;
    assign ex_stall   = ex_valid && state_q != RESP;
    assign res_valid  = state_q == RESP && !flush;
    assign res_data   = res_valid ? res_q : '0;
    assign res_rd     = res_valid ? rd_q : '0;
    assign div_valid  = busy;
    assign div_signed = busy & ~op_q[0];
    assign divw       = busy & word_q;
    assign dividend   = busy ? src1_q : '0;
    assign divisor    = busy ? src2_q : '0;
    assign div_flush  = flush & busy;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        word_d  = word_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        rd_d    = rd_q;
        res_d   = res_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (ex_valid) begin
                    op_d    = ex_op;
                    word_d  = ex_word;
                    src1_d  = ex_src1;
                    src2_d  = ex_src2;
                    rd_d    = ex_rd;
                    res_d   = special ? fmt(ex_word, spec_raw) : res_q;
                    state_d = special ? RESP : BUSY;
                end
                BUSY: if (out_valid) begin
                    res_d   = fmt(word_q, op_q[1] ? rema : quot);
                    state_d = RESP;
                end
                RESP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            word_q  <= 1'b0;
            src1_q  <= '0;
            src2_q  <= '0;
            rd_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            word_q  <= word_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
        end
    end

`ifdef YSYX_22041071_DIV_PERF_EN
    logic [63:0] perf_div_ops_q, perf_busy_cyc_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_div_ops_q  <= '0;
            perf_busy_cyc_q <= '0;
        end else begin
            perf_div_ops_q  <= perf_div_ops_q + {63'd0, res_valid};
            perf_busy_cyc_q <= perf_busy_cyc_q + {63'd0, busy};
        end
    end

    assign perf_div_ops  = perf_div_ops_q;
    assign perf_busy_cyc = perf_busy_cyc_q;
`endif
endmodule

// File: tb/tb_ysyx_22041071_div_ctrl.sv
// tb_ysyx_22041071_div_ctrl: vector table, random ops and corner sequences against a spec-level model.
// Perf counter checks are built when YSYX_22041071_DIV_PERF_EN is defined.
module tb_ysyx_22041071_div_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ex_valid = 1'b0, ex_word = 1'b0, flush = 1'b0;
    logic [1:0]  ex_op = '0;
    logic [63:0] ex_src1 = '0, ex_src2 = '0;
    logic [4:0]  ex_rd = '0;
    logic        ex_stall, res_valid, div_valid, div_signed, divw, div_flush, div_ready, out_valid;
    logic [63:0] res_data, dividend, divisor, quot, rema;
    logic [4:0]  res_rd;
`ifdef YSYX_22041071_DIV_PERF_EN
    logic [63:0] perf_div_ops, perf_busy_cyc;
`endif

    int checks = 0, failures = 0;
    int lat = 3;
    logic stray_ov = 1'b0;

    ysyx_22041071_div_ctrl #(.XLEN(64), .TAG_W(5)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_op(ex_op), .ex_word(ex_word),
        .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_rd(ex_rd), .flush(flush),
        .ex_stall(ex_stall), .res_valid(res_valid), .res_data(res_data), .res_rd(res_rd),
        .div_valid(div_valid), .div_signed(div_signed), .divw(divw), .dividend(dividend),
        .divisor(divisor), .div_flush(div_flush), .div_ready(div_ready), .out_valid(out_valid),
        .quot(quot), .rema(rema)
`ifdef YSYX_22041071_DIV_PERF_EN
        , .perf_div_ops(perf_div_ops), .perf_busy_cyc(perf_busy_cyc)
`endif
    );

    always #5 clk = ~clk;

    // Divider stand-in: returns raw low-word results for W requests, so sign extension is the DUT's job.
    function automatic logic [127:0] mdl_div(input logic s, input logic w, input logic [63:0] a, input logic [63:0] b);
        logic signed [31:0] a32, b32;
        logic signed [63:0] a64, b64;
        a32 = a[31:0]; b32 = b[31:0]; a64 = a; b64 = b;
        if (w ? (b[31:0] == 0) : (b == 0)) return {2{64'hDEAD_DEAD_DEAD_DEAD}};
        if (s && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1) : (a == 64'h8000_0000_0000_0000 && b == '1)))
            return {2{64'hBAD0_BAD0_BAD0_BAD0}};
        if (w) return s ? {32'd0, 32'(a32 / b32), 32'd0, 32'(a32 % b32)}
                        : {32'd0, a[31:0] / b[31:0], 32'd0, a[31:0] % b[31:0]};
        return s ? {64'(a64 / b64), 64'(a64 % b64)} : {a / b, a % b};
    endfunction

    function automatic logic is_ovf(input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
        return !op[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1) : (a == 64'h8000_0000_0000_0000 && b == '1));
    endfunction

    function automatic logic is_spec(input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
        return (w ? (b[31:0] == 0) : (b == 0)) || is_ovf(op, w, a, b);
    endfunction

    function automatic logic [63:0] ref_res(input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] ua, ub, q, r, res;
        ua = w ? {32'd0, a[31:0]} : a;
        ub = w ? {32'd0, b[31:0]} : b;
        sa = w ? {{32{a[31]}}, a[31:0]} : a;
        sb = w ? {{32{b[31]}}, b[31:0]} : b;
        if (ub == 0) begin q = '1; r = a; end
        else if (is_ovf(op, w, a, b)) begin q = a; r = '0; end
        else if (!op[0]) begin q = 64'(sa / sb); r = 64'(sa % sb); end
        else begin q = ua / ub; r = ua % ub; end
        res = op[1] ? r : q;
        return w ? {{32{res[31]}}, res[31:0]} : res;
    endfunction

    logic        mdl_busy = 1'b0, mdl_ov = 1'b0, cap_s = 1'b0, cap_w = 1'b0;
    logic [63:0] cap_a = '0, cap_b = '0, mdl_q = '0, mdl_r = '0;
    int          mdl_cnt = 0, acc_cnt = 0, dv_cnt = 0, stab_err = 0;

    assign div_ready = !mdl_busy;
    assign out_valid = mdl_ov | stray_ov;
    assign quot = stray_ov ? 64'h1111_2222_3333_4444 : mdl_q;
    assign rema = stray_ov ? 64'h5555_6666_7777_8888 : mdl_r;

    always @(posedge clk) begin
        if (div_valid) dv_cnt <= dv_cnt + 1;
        if (!reset || div_flush) begin
            mdl_busy <= 1'b0;
            mdl_ov   <= 1'b0;
        end else if (!mdl_busy) begin
            if (div_valid) begin
                mdl_busy <= 1'b1; mdl_cnt <= lat; acc_cnt <= acc_cnt + 1;
                cap_s <= div_signed; cap_w <= divw; cap_a <= dividend; cap_b <= divisor;
            end
        end else begin
            if ({div_valid, div_signed, divw, dividend, divisor} != {1'b1, cap_s, cap_w, cap_a, cap_b})
                stab_err <= stab_err + 1;
            if (mdl_ov) begin
                mdl_busy <= 1'b0; mdl_ov <= 1'b0;
            end else if (mdl_cnt <= 1) begin
                mdl_ov <= 1'b1;
                {mdl_q, mdl_r} <= mdl_div(cap_s, cap_w, cap_a, cap_b);
            end else mdl_cnt <= mdl_cnt - 1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic any_out();
        return |{ex_stall, res_valid, res_data, res_rd, div_valid, div_signed, divw, dividend, divisor, div_flush};
    endfunction

    task automatic do_op(input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd, input logic [63:0] exp, input string nm);
        int dv0, acc0, n;
        logic seen, prev_ov, spc;
        spc = is_spec(op, w, a, b);
        dv0 = dv_cnt; acc0 = acc_cnt;
        ex_valid = 1'b1; ex_op = op; ex_word = w; ex_src1 = a; ex_src2 = b; ex_rd = rd;
        #1;
        chk({nm, "_stall"}, 64'(ex_stall), 64'd1);
        seen = 1'b0; prev_ov = 1'b0; n = 0;
        while (!seen && n < 300) begin
            prev_ov = out_valid;
            step();
            n++;
            if (n == 2 && !spc) chk({nm, "_div_accept"}, 64'(acc_cnt), 64'(acc0 + 1));
            seen = res_valid;
        end
        if (!seen) chk({nm, "_timeout"}, 64'(n), 64'd0);
        else begin
            chk({nm, "_data"}, res_data, exp);
            chk({nm, "_rd"}, 64'(res_rd), 64'(rd));
            chk({nm, "_stall_resp"}, 64'(ex_stall), 64'd0);
            chk({nm, "_latency"}, spc ? 64'(n) : 64'(prev_ov), 64'd1);
            chk({nm, "_divreq"}, 64'(dv_cnt != dv0), 64'(!spc));
            if (!spc) chk({nm, "_sgn_w"}, {62'd0, cap_s, cap_w}, {62'd0, !op[0], w});
        end
        step();
        ex_valid = 1'b0;
        chk({nm, "_pulse"}, 64'(res_valid), 64'd0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic        w;
        logic [63:0] a, b;
        logic [4:0]  rd;
        logic [63:0] exp;
    } vec_t;
    vec_t tbl[14];

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd1, 64'hFFFF_FFFF_FFFF_FFFD};
        tbl[1]  = '{2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[2]  = '{2'b01, 1'b1, 64'h1_8000_0000, 64'd2, 5'd3, 64'h0000_0000_4000_0000};
        tbl[3]  = '{2'b00, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4, 64'hFFFF_FFFF_8000_0000};
        tbl[4]  = '{2'b01, 1'b0, 64'd5, 64'd0, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[5]  = '{2'b10, 1'b1, 64'h8000_0003, 64'd0, 5'd6, 64'hFFFF_FFFF_8000_0003};
        tbl[6]  = '{2'b00, 1'b0, 64'd100, 64'd7, 5'd7, 64'd14};
        tbl[7]  = '{2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8, 64'd0};
        tbl[8]  = '{2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 64'h8000_0000_0000_0000};
        tbl[9]  = '{2'b11, 1'b0, 64'd100, 64'd7, 5'd10, 64'd2};
        tbl[10] = '{2'b00, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 5'd11, 64'hFFFF_FFFF_FFFF_FFFD};
        tbl[11] = '{2'b01, 1'b1, 64'd77, 64'h1_0000_0000, 5'd12, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[12] = '{2'b11, 1'b1, 64'h7777_7777_FFFF_FFFF, 64'd10, 5'd13, 64'd5};
        tbl[13] = '{2'b01, 1'b1, 64'hFFFF_FFF0, 64'd1, 5'd14, 64'hFFFF_FFFF_FFFF_FFF0};

        step(); step();
        chk("reset_outputs", 64'(any_out()), 64'd0);
        reset = 1'b1;
        step();

        for (int i = 0; i < 14; i++) begin
            lat = 1 + i % 4;
            do_op(tbl[i].op, tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 60; i++) begin
            logic [1:0]  op;
            logic        w;
            logic [63:0] a, b;
            op = 2'($urandom_range(0, 3));
            w  = 1'($urandom_range(0, 1));
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = '1;
                2: b = 64'($urandom_range(1, 20));
                3: begin a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000; b = '1; end
                4: b = {$urandom, 32'h0};
                default: ;
            endcase
            lat = $urandom_range(1, 5);
            do_op(op, w, a, b, 5'($urandom), ref_res(op, w, a, b), $sformatf("rnd%0d", i));
        end

        lat = 60;
        ex_valid = 1'b1; ex_op = 2'b00; ex_word = 1'b0; ex_src1 = 64'd200; ex_src2 = 64'd3; ex_rd = 5'd9;
        repeat (20) step();
        chk("flush20_busy", 64'(div_valid), 64'd1);
        flush = 1'b1; ex_valid = 1'b0;
        #1;
        chk("flush20_div_flush", 64'(div_flush), 64'd1);
        step();
        flush = 1'b0;
        #1;
        chk("flush20_idle", {62'd0, div_valid, div_flush}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush20_no_res", 64'(res_valid), 64'd0);
        end
        lat = 3;
        do_op(2'b00, 1'b0, 64'd100, 64'd7, 5'd21, 64'd14, "after_flush");

        lat = 4;
        ex_valid = 1'b1; ex_op = 2'b10; ex_word = 1'b0; ex_src1 = 64'd100; ex_src2 = 64'd7; ex_rd = 5'd22;
        begin
            int n = 0;
            while (!out_valid && n < 50) begin step(); n++; end
            chk("flush_ov_seen", 64'(out_valid), 64'd1);
        end
        flush = 1'b1; ex_valid = 1'b0;
        #1;
        chk("flush_ov_div_flush", 64'(div_flush), 64'd1);
        step();
        flush = 1'b0;
        #1;
        chk("flush_ov_discard", {62'd0, res_valid, div_valid}, 64'd0);
        step();

        ex_valid = 1'b1; flush = 1'b1; ex_op = 2'b00; ex_src1 = 64'd9; ex_src2 = 64'd3;
        step();
        chk("flush_idle_norm", 64'(div_valid), 64'd0);
        ex_src2 = 64'd0;
        step();
        chk("flush_idle_spec", 64'(res_valid), 64'd0);
        ex_valid = 1'b0; flush = 1'b0;
        step();

        stray_ov = 1'b1;
        step();
        stray_ov = 1'b0;
        #1;
        chk("stray_ov", {62'd0, res_valid, div_valid}, 64'd0);
        lat = 2;
        do_op(2'b11, 1'b0, 64'd50, 64'd8, 5'd23, 64'd2, "after_stray");

        lat = 50;
        ex_valid = 1'b1; ex_op = 2'b01; ex_word = 1'b0; ex_src1 = 64'd1000; ex_src2 = 64'd9; ex_rd = 5'd24;
        repeat (3) step();
        reset = 1'b0; ex_valid = 1'b0;
        step();
        chk("reset_mid_busy", 64'(any_out()), 64'd0);
        reset = 1'b1;
        step();
        chk("stability", 64'(stab_err), 64'd0);

`ifdef YSYX_22041071_DIV_PERF_EN
        chk("perf_reset", perf_div_ops | perf_busy_cyc, 64'd0);
        lat = 2;
        do_op(2'b00, 1'b0, 64'd100, 64'd7, 5'd1, 64'd14, "perf_a");
        do_op(2'b01, 1'b0, 64'd5, 64'd0, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF, "perf_b");
        do_op(2'b00, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 64'hFFFF_FFFF_8000_0000, "perf_c");
        chk("perf_div_ops", perf_div_ops, 64'd3);
        chk("perf_busy_cyc", perf_busy_cyc, 64'd4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
